// File: rtl/si_fifo_peer.sv
// si endpoint for the host byte transport: RX FIFO feeding an si producer, and an
// si sink capturing write strobes into a show-ahead TX FIFO drained by the host.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// P_IDLE    | nothing presented; pops RX head as soon as one is buffered
// P_PRESENT | rx_data_si/rx_rdy_si held until the consumer acks
// S_READY   | sink idle, tx_ack_si low
// S_ACK     | one-cycle acknowledge after an accepted strobe
// S_FULL    | TX FIFO full; tx_ack_si held high until a slot frees
module si_fifo_peer #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] rx_data_si,
    output logic             rx_rdy_si,
    input  logic             rx_ack_si,
    input  logic [WIDTH-1:0] tx_data_si,
    input  logic             tx_rdy_si,
    output logic             tx_ack_si,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             tx_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {P_IDLE, P_PRESENT} p_state_t;
    typedef enum logic [1:0] {S_READY, S_ACK, S_FULL} s_state_t;

    // ---------------- RX path ----------------
    logic [WIDTH-1:0]      rx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
    logic                  rx_wr, rx_pop;

    p_state_t              p_state_q, p_state_d;
    logic [WIDTH-1:0]      rx_data_q, rx_data_d;
    logic                  rx_rdy_q, rx_rdy_d;

    assign in_ready   = (rx_cnt_q != FULL_CNT);
    assign rx_wr      = in_valid && in_ready;
    assign rx_data_si = rx_data_q;
    assign rx_rdy_si  = rx_rdy_q;

    always_comb begin
        p_state_d = p_state_q;
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q;
        rx_pop    = 1'b0;
        case (p_state_q)
            P_IDLE: begin
                if (rx_cnt_q != '0) begin
                    rx_pop    = 1'b1;
                    rx_data_d = rx_mem_q[rx_rd_ptr_q];
                    rx_rdy_d  = 1'b1;
                    p_state_d = P_PRESENT;
                end
            end
            P_PRESENT: begin
                if (rx_ack_si) begin
                    rx_rdy_d  = 1'b0;
                    p_state_d = P_IDLE;
                end
            end
            default: begin
                rx_rdy_d  = 1'b0;
                p_state_d = P_IDLE;
            end
        endcase
    end

    always_comb begin
        rx_wr_ptr_d = rx_wr ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
        rx_rd_ptr_d = rx_pop ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;
        rx_cnt_d    = rx_cnt_q;
        if (rx_wr && !rx_pop) begin
            rx_cnt_d = rx_cnt_q + CNT_ONE;
        end else if (!rx_wr && rx_pop) begin
            rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_wr) begin
            rx_mem_q[rx_wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            p_state_q   <= P_IDLE;
            rx_data_q   <= '0;
            rx_rdy_q    <= 1'b0;
        end else begin
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            p_state_q   <= p_state_d;
            rx_data_q   <= rx_data_d;
            rx_rdy_q    <= rx_rdy_d;
        end
    end

    // ---------------- TX path ----------------
    logic [WIDTH-1:0]      tx_mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;
    logic                  tx_full, tx_accept, tx_pop;

    s_state_t              s_state_q, s_state_d;
    logic                  tx_ack_q, tx_ack_d;
    logic                  tx_ovf_q, tx_ovf_d;

    // Full is taken from the pre-edge count, so a same-edge pop never rescues a strobe.
    assign tx_full     = (tx_cnt_q == FULL_CNT);
    assign tx_accept   = tx_rdy_si && !tx_full;
    assign out_valid   = (tx_cnt_q != '0);
    assign tx_pop      = out_valid && out_ready;
    assign out_data    = tx_mem_q[tx_rd_ptr_q];
    assign tx_ack_si   = tx_ack_q;
    assign tx_overflow = tx_ovf_q;

    always_comb begin
        tx_wr_ptr_d = tx_accept ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
        tx_rd_ptr_d = tx_pop ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q;
        if (tx_accept && !tx_pop) begin
            tx_cnt_d = tx_cnt_q + CNT_ONE;
        end else if (!tx_accept && tx_pop) begin
            tx_cnt_d = tx_cnt_q - CNT_ONE;
        end
    end

    always_comb begin
        s_state_d = s_state_q;
        if (tx_accept) begin
            s_state_d = (tx_cnt_d == FULL_CNT) ? S_FULL : S_ACK;
        end else begin
            case (s_state_q)
                S_ACK:   s_state_d = (tx_cnt_d == FULL_CNT) ? S_FULL : S_READY;
                S_FULL:  s_state_d = (tx_cnt_d == FULL_CNT) ? S_FULL : S_READY;
                default: s_state_d = S_READY;
            endcase
        end
        tx_ack_d = (s_state_d != S_READY);
        tx_ovf_d = tx_ovf_q || (tx_rdy_si && tx_full);
    end

    always_ff @(posedge clk) begin
        if (tx_accept) begin
            tx_mem_q[tx_wr_ptr_q] <= tx_data_si;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            s_state_q   <= S_READY;
            tx_ack_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
        end else begin
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            s_state_q   <= s_state_d;
            tx_ack_q    <= tx_ack_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

endmodule

// File: tb/tb_si_fifo_peer.sv
// Scoreboard bench for si_fifo_peer: bytes queued on acceptance, compared when the
// si consumer acks (RX) or the host pops (TX).
module tb_si_fifo_peer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] rx_data_si;
    logic       rx_rdy_si;
    logic       rx_ack_si = 1'b0;
    logic [7:0] tx_data_si = '0;
    logic       tx_rdy_si = 1'b0;
    logic       tx_ack_si;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       tx_overflow;

    int total = 0;
    int bad   = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];

    si_fifo_peer #(.WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
        .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge with inputs settled: records accepts, checks completions,
    // then advances one active edge and returns at the following negedge.
    task automatic tick();
        logic [7:0] exp;
        if (in_valid && in_ready) rxq.push_back(in_data);
        if (tx_rdy_si && txq.size() < 16) txq.push_back(tx_data_si);
        if (rx_rdy_si && rx_ack_si) begin
            total++;
            if (rxq.size() == 0) begin
                bad++;
                $display("FAIL rx_sb: got unexpected word %02h, want none", rx_data_si);
            end else begin
                exp = rxq.pop_front();
                if (rx_data_si !== exp) begin
                    bad++;
                    $display("FAIL rx_sb: got %02h want %02h", rx_data_si, exp);
                end
            end
        end
        if (out_valid && out_ready) begin
            total++;
            if (txq.size() == 0) begin
                bad++;
                $display("FAIL tx_sb: got unexpected word %02h, want none", out_data);
            end else begin
                exp = txq.pop_front();
                if (out_data !== exp) begin
                    bad++;
                    $display("FAIL tx_sb: got %02h want %02h", out_data, exp);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 0; rx_ack_si = 0; tx_rdy_si = 0; out_ready = 0;
        rxq.delete();
        txq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL reset_rx_rdy: got %b want 0", rx_rdy_si); end
        total++; if (rx_data_si !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %02h want 00", rx_data_si); end
        total++; if (tx_ack_si !== 1'b0) begin bad++; $display("FAIL reset_tx_ack: got %b want 0", tx_ack_si); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", tx_overflow); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_rx_single();
        in_data = 8'hA5; in_valid = 1;
        tick();
        in_valid = 0;
        total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL rx1_latency: rdy got %b want 0", rx_rdy_si); end
        tick();
        total++; if (rx_rdy_si !== 1'b1) begin bad++; $display("FAIL rx1_rdy: got %b want 1", rx_rdy_si); end
        total++; if (rx_data_si !== 8'hA5) begin bad++; $display("FAIL rx1_data: got %02h want a5", rx_data_si); end
        rx_ack_si = 1;
        tick();
        rx_ack_si = 0;
        total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL rx1_ack_drop: rdy got %b want 0", rx_rdy_si); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL rx1_empty_rdy: got %b want 0", rx_rdy_si); end
        end
    endtask

    task automatic test_rx_burst();
        for (int i = 1; i <= 17; i++) begin
            in_data = 8'(i); in_valid = 1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL burst_in_ready: write %0d got %b want 1", i, in_ready); end
            tick();
        end
        in_data = 8'h77;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL burst_full: in_ready got %b want 0", in_ready); end
        tick();
        in_valid = 0;
        total++; if (rx_data_si !== 8'h01) begin bad++; $display("FAIL burst_head: got %02h want 01", rx_data_si); end
        for (int w = 0; w < 17; w++) begin
            total++; if (rx_rdy_si !== 1'b1) begin bad++; $display("FAIL burst_rdy: word %0d got %b want 1", w, rx_rdy_si); end
            rx_ack_si = 1;
            tick();
            rx_ack_si = 0;
            total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL burst_gap: word %0d rdy got %b want 0", w, rx_rdy_si); end
            tick();
            if (w == 0) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL burst_ready_back: got %b want 1", in_ready); end
            end
        end
        total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL burst_end_rdy: got %b want 0", rx_rdy_si); end
        total++; if (rxq.size() != 0) begin bad++; $display("FAIL burst_left: got %0d queued want 0", rxq.size()); end
    endtask

    task automatic test_tx_single();
        tx_data_si = 8'h3C; tx_rdy_si = 1;
        tick();
        tx_rdy_si = 0;
        total++; if (tx_ack_si !== 1'b1) begin bad++; $display("FAIL tx1_ack: got %b want 1", tx_ack_si); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL tx1_valid: got %b want 1", out_valid); end
        total++; if (out_data !== 8'h3C) begin bad++; $display("FAIL tx1_data: got %02h want 3c", out_data); end
        tick();
        total++; if (tx_ack_si !== 1'b0) begin bad++; $display("FAIL tx1_ack_len: got %b want 0", tx_ack_si); end
        out_ready = 1;
        tick();
        out_ready = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tx1_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_tx_full();
        for (int i = 0; i < 16; i++) begin
            tx_data_si = 8'(8'h10 + i); tx_rdy_si = 1;
            tick();
        end
        total++; if (tx_ack_si !== 1'b1) begin bad++; $display("FAIL full_ack: got %b want 1", tx_ack_si); end
        total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL full_ovf_early: got %b want 0", tx_overflow); end
        tx_data_si = 8'hFF;
        tick();
        tx_rdy_si = 0;
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL full_ovf: got %b want 1", tx_overflow); end
        tick();
        total++; if (tx_ack_si !== 1'b1) begin bad++; $display("FAIL full_ack_hold: got %b want 1", tx_ack_si); end
        total++; if (out_data !== 8'h10) begin bad++; $display("FAIL full_head: got %02h want 10", out_data); end
        out_ready = 1;
        tick();
        out_ready = 0;
        total++; if (tx_ack_si !== 1'b0) begin bad++; $display("FAIL full_pop_ack: got %b want 0", tx_ack_si); end
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL full_ovf_sticky: got %b want 1", tx_overflow); end
        out_ready = 1;
        for (int i = 0; i < 15; i++) tick();
        out_ready = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_drain: valid got %b want 0", out_valid); end
    endtask

    task automatic test_strobe_pop_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            tx_data_si = 8'(8'h40 + i); tx_rdy_si = 1;
            tick();
        end
        tx_data_si = 8'hEE; out_ready = 1;
        tick();
        tx_rdy_si = 0; out_ready = 0;
        total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL sp_ovf: got %b want 1", tx_overflow); end
        total++; if (tx_ack_si !== 1'b0) begin bad++; $display("FAIL sp_ack: got %b want 0", tx_ack_si); end
        out_ready = 1;
        for (int i = 0; i < 15; i++) tick();
        out_ready = 0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sp_drain: valid got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        int n;
        n = 0;
        rx_ack_si = 1;
        for (int c = 0; c < 400 && n < 40; c++) begin
            in_data = 8'($urandom_range(0, 255)); in_valid = 1;
            if (in_ready) n++;
            tick();
        end
        in_valid = 0;
        total++; if (n != 40) begin bad++; $display("FAIL wrap_rx_accept: got %0d writes want 40", n); end
        for (int c = 0; c < 100 && (rxq.size() != 0 || rx_rdy_si); c++) tick();
        rx_ack_si = 0;
        total++; if (rxq.size() != 0) begin bad++; $display("FAIL wrap_rx_left: got %0d want 0", rxq.size()); end
        out_ready = 1;
        for (int i = 0; i < 40; i++) begin
            tx_data_si = 8'($urandom_range(0, 255)); tx_rdy_si = 1;
            tick();
        end
        tx_rdy_si = 0;
        for (int c = 0; c < 40 && txq.size() != 0; c++) tick();
        out_ready = 0;
        total++; if (txq.size() != 0) begin bad++; $display("FAIL wrap_tx_left: got %0d want 0", txq.size()); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_tx_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(8'h80 + i); in_valid = 1;
            tx_data_si = 8'(8'hC0 + i); tx_rdy_si = (i < 3);
            tick();
        end
        in_valid = 0; tx_rdy_si = 1; tx_data_si = 8'hC3;
        rst_n = 1'b0;
        #1;
        total++; if (rx_rdy_si !== 1'b0) begin bad++; $display("FAIL mid_rx_rdy: got %b want 0", rx_rdy_si); end
        total++; if (tx_ack_si !== 1'b0) begin bad++; $display("FAIL mid_tx_ack: got %b want 0", tx_ack_si); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
        tx_rdy_si = 0;
        rxq.delete();
        txq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (rx_rdy_si !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL mid_stale: rdy=%b valid=%b want 0 0", rx_rdy_si, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rx_single();
        test_rx_burst();
        test_tx_single();
        test_tx_full();
        test_strobe_pop_full();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
